// File: rtl/simple_mem_pkg.sv
// simple_mem_pkg: shared types and defaults for the memory responder.
// Build option MEM_OOR_ERR_EN enables out-of-range error reporting.
package simple_mem_pkg;

  localparam int MEM_ADDR_W  = 8;
  localparam int MEM_DATA_W  = 8;
  localparam int MEM_DEPTH   = 256;
  localparam int MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Bits needed to index n items, never less than one.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/simple_mem_if.sv
// simple_mem_if: CPU data-memory port bundle with master/slave views.
// mem_err exists only when MEM_OOR_ERR_EN is defined.
interface simple_mem_if
  import simple_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
`ifdef MEM_OOR_ERR_EN
  logic              mem_err;
`endif

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
`ifdef MEM_OOR_ERR_EN
    input  mem_err,
`endif
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
`ifdef MEM_OOR_ERR_EN
    output mem_err,
`endif
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/simple_mem_array.sv
// simple_mem_array: DEPTH x DATA_W storage, sync write, comb read.
// Contents are deliberately not reset.
module simple_mem_array
  import simple_mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int IDX_W  = width_for(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit write data on the enabled edge.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/simple_mem_responder.sv
// simple_mem_responder: fixed-latency single-beat memory responder.
// Define MEM_OOR_ERR_EN to flag and suppress addresses >= DEPTH.
module simple_mem_responder
  import simple_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int LATENCY = MEM_LATENCY
) (
  input logic       clk,
  input logic       rst_n,
  simple_mem_if.slave bus
);

  localparam int IDX_W = width_for(DEPTH);
  localparam int CNT_W = width_for(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("simple_mem_responder: LATENCY must be >= 1");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("simple_mem_responder: DEPTH out of range");
  end
  if (ADDR_W > MEM_ADDR_W || DATA_W > MEM_DATA_W) begin : g_bad_width
    $error("simple_mem_responder: widths exceed capture struct");
  end

  mem_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  mem_req_t          cap;

  logic              capture;
  logic              oor;
  logic              arr_we;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] arr_rdata;

  assign capture = (state == IDLE) && bus.mem_req;
  assign idx     = bus.mem_addr[IDX_W-1:0];

`ifdef MEM_OOR_ERR_EN
  assign oor = {1'b0, bus.mem_addr} >= (ADDR_W + 1)'(DEPTH);
`else
  assign oor = 1'b0;
`endif

  if (ADDR_W > IDX_W) begin : g_hi_addr
    logic unused_hi;
    assign unused_hi = ^bus.mem_addr[ADDR_W-1:IDX_W];
  end

  assign arr_we = capture && bus.mem_we && !oor;

  simple_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (idx),
    .wdata (bus.mem_wdata),
    .rdata (arr_rdata)
  );

  // Request FSM: capture, count wait states, pulse ready in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      cap     <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_req) begin
            cap.we    <= bus.mem_we;
            cap.addr  <= MEM_ADDR_W'(bus.mem_addr);
            cap.wdata <= MEM_DATA_W'(bus.mem_wdata);
            if (!bus.mem_we) rdata_q <= oor ? '0 : arr_rdata;
            cnt <= CNT_LOAD;
            if (LATENCY == 1) begin
              state   <= RESP;
              ready_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= RESP;
            ready_q <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

`ifdef MEM_OOR_ERR_EN
  logic err_q;
  logic cap_oor;
  logic unused_cap;

  assign cap_oor    = {1'b0, cap.addr} >= (MEM_ADDR_W + 1)'(DEPTH);
  assign unused_cap = ^{cap.we, cap.wdata};

  // Error flag is raised only for the RESP cycle of an OOR access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (capture && LATENCY == 1) err_q <= oor;
      else if (state == WAIT && cnt == CNT_ONE) err_q <= cap_oor;
    end
  end

  assign bus.mem_err = err_q;
`else
  logic unused_cap;
  assign unused_cap = ^cap;
`endif

endmodule
